// File: rtl/pll_reconfig_ctrl.sv
// Run-time FBDSEL/IDSEL sequencer for the fabric rPLL: gates clk_en, applies new dividers, waits for re-lock.
// Optional lock-timeout supervision is built when PLLCFG_TIMEOUT_EN is defined.
module pll_reconfig_ctrl #(
    parameter int unsigned DEF_IDIV      = 2,
    parameter int unsigned DEF_FBDIV     = 13,
    parameter int unsigned GATE_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idiv,
    input  logic [5:0] req_fbdiv,
    input  logic       pll_lock,
    output logic [5:0] fbdsel,
    output logic [5:0] idsel,
    output logic       clk_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DONE_ONLY,
        S_GATE,
        S_APPLY,
        S_SETTLE,
        S_WAIT_LOCK,
        S_RELEASE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lock_sync;
    logic       lock_s;
    logic [7:0] cnt;
    logic [5:0] pend_idiv;
    logic [5:0] pend_fbdiv;
    logic       accept;
    logic       same_cfg;
    logic       timeout_hit;

    assign lock_s   = lock_sync[1];
    assign accept   = (state == S_IDLE) && req_valid;
    // Selects hold the complement of the active settings, so compare against their inverse.
    assign same_cfg = (req_idiv == ~idsel) && (req_fbdiv == ~fbdsel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = same_cfg ? S_DONE_ONLY : S_GATE;
            S_DONE_ONLY: state_nxt = S_IDLE;
            S_GATE:      if (cnt == 8'(GATE_CYCLES - 1)) state_nxt = S_APPLY;
            S_APPLY:     state_nxt = S_SETTLE;
            S_SETTLE:    if (cnt == 8'(SETTLE_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: if (lock_s || timeout_hit) state_nxt = S_RELEASE;
            S_RELEASE:   state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        clk_en    = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_DONE_ONLY: done = 1'b1;
            S_GATE, S_APPLY, S_SETTLE, S_WAIT_LOCK: clk_en = 1'b0;
            S_RELEASE: done = !err;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_sync  <= '0;
            cnt        <= '0;
            pend_idiv  <= 6'(DEF_IDIV);
            pend_fbdiv <= 6'(DEF_FBDIV);
            idsel      <= ~6'(DEF_IDIV);
            fbdsel     <= ~6'(DEF_FBDIV);
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
            if (accept) begin
                pend_idiv  <= req_idiv;
                pend_fbdiv <= req_fbdiv;
            end
            // Shared counter: runs in GATE and SETTLE, cleared everywhere else (including APPLY).
            if (state == S_GATE || state == S_SETTLE) begin
                cnt <= cnt + 8'd1;
            end else begin
                cnt <= '0;
            end
            if (state == S_APPLY) begin
                idsel  <= ~pend_idiv;
                fbdsel <= ~pend_fbdiv;
            end
        end
    end

`ifdef PLLCFG_TIMEOUT_EN
    logic [15:0] tcnt;

    assign timeout_hit = (state == S_WAIT_LOCK) && !lock_s && (tcnt == 16'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= (state == S_WAIT_LOCK) ? tcnt + 16'd1 : '0;
            if (accept) begin
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^16'(LOCK_TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: directed table, multi-cycle corner sequences and a
// randomized run against an event-time reference model. Timeout cases build with PLLCFG_TIMEOUT_EN.
module tb_pll_reconfig_ctrl;

    localparam int unsigned G  = 4;
    localparam int unsigned S  = 8;
    localparam int unsigned LT = 64;
    localparam int unsigned DI = 2;
    localparam int unsigned DF = 13;
`ifdef PLLCFG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int NONE = 32'h7fff_ffff;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_idiv;
    logic [5:0] req_fbdiv;
    logic       pll_lock;
    logic [5:0] fbdsel;
    logic [5:0] idsel;
    logic       clk_en;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .DEF_IDIV(DI),
        .DEF_FBDIV(DF),
        .GATE_CYCLES(G),
        .SETTLE_CYCLES(S),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_idiv(req_idiv),
        .req_fbdiv(req_fbdiv),
        .pll_lock(pll_lock),
        .fbdsel(fbdsel),
        .idsel(idsel),
        .clk_en(clk_en),
        .busy(busy),
        .done(done),
        .err(err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 1'b0;
    bit lockhist [MAXC];

    // Reference model: absolute cycle numbers at which each observable event happens.
    int free_at = NONE;
    int gate_lo = NONE;
    int rel_at  = NONE;
    int sel_at  = 0;
    int wait_at = NONE;
    int done_at = NONE;
    int err_at  = NONE;
    logic [5:0] old_i, old_f, new_i, new_f;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {5'b0, act}, {5'b0, exp});
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int c1);
        free_at = c1;
        gate_lo = NONE;
        rel_at  = NONE;
        sel_at  = 0;
        wait_at = NONE;
        done_at = NONE;
        err_at  = NONE;
        old_i = 6'(DI);
        new_i = 6'(DI);
        old_f = 6'(DF);
        new_f = 6'(DF);
    endtask

    // Drive one cycle of inputs, advance the clock, update the model and compare all outputs.
    task automatic step(input logic v, input logic [5:0] i, input logic [5:0] f,
                        input logic lk, input logic rn);
        int c;
        logic ls;
        logic [5:0] ef, ei;
        c = cyc;
        req_valid = v;
        req_idiv  = i;
        req_fbdiv = f;
        pll_lock  = lk;
        rst_n     = rn;
        if (c < MAXC) lockhist[c] = lk;
        if (!rn) begin
            model_reset(c + 1);
            if (c < MAXC) lockhist[c] = 1'b0;
            if (c >= 1 && c <= MAXC) lockhist[c-1] = 1'b0;
        end else if (armed && v && c >= free_at) begin
            old_i = new_i;
            old_f = new_f;
            err_at = NONE;
            if (i == new_i && f == new_f) begin
                done_at = c + 1;
                free_at = c + 2;
            end else begin
                new_i   = i;
                new_f   = f;
                gate_lo = c + 1;
                sel_at  = c + int'(G) + 2;
                wait_at = c + int'(G) + int'(S) + 2;
                rel_at  = NONE;
                free_at = NONE;
                done_at = NONE;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rn) armed = 1'b1;
        if (armed) begin
            if (rel_at == NONE && wait_at != NONE && cyc >= wait_at) begin
                ls = (cyc >= 2 && cyc - 2 < MAXC) ? lockhist[cyc-2] : 1'b0;
                if (ls) begin
                    rel_at  = cyc + 1;
                    done_at = cyc + 1;
                    free_at = cyc + 2;
                end else if (TO_EN && (cyc - wait_at + 1 == int'(LT))) begin
                    rel_at  = cyc + 1;
                    err_at  = cyc + 1;
                    free_at = cyc + 2;
                end
            end
            ef = (cyc >= sel_at) ? new_f : old_f;
            ei = (cyc >= sel_at) ? new_i : old_i;
            chk1("m_ready", req_ready, cyc >= free_at);
            chk1("m_busy", busy, cyc < free_at);
            chk1("m_clk_en", clk_en, !(cyc >= gate_lo && cyc < rel_at));
            chk1("m_done", done, cyc == done_at);
            chk1("m_err", err, cyc >= err_at);
            chk("m_fbdsel", fbdsel, ~ef);
            chk("m_idsel", idsel, ~ei);
        end
    endtask

    typedef struct {
        int         reps;
        logic       v;
        logic [5:0] i;
        logic [5:0] f;
        logic       lk;
        logic       e_ready;
        logic       e_busy;
        logic       e_clk;
        logic       e_done;
        logic [5:0] e_fb;
        logic [5:0] e_id;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int first_done;
        bit saw_done;
        logic lk;

        // Request idiv=0/fbdiv=4 accepted at T with lock already high, then a repeat of it.
        tbl[0] = '{1, 1'b1, 6'd0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110010, 6'b111101};
        tbl[1] = '{4, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b110010, 6'b111101};
        tbl[2] = '{9, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111011, 6'b111111};
        tbl[3] = '{1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b111011, 6'b111111};
        tbl[4] = '{1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b111011, 6'b111111};
        tbl[5] = '{1, 1'b1, 6'd0, 6'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b111011, 6'b111111};
        tbl[6] = '{1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b111011, 6'b111111};
        tbl[7] = '{2, 1'b0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b111011, 6'b111111};

        req_valid = 1'b0;
        req_idiv  = '0;
        req_fbdiv = '0;
        pll_lock  = 1'b1;
        rst_n     = 1'b0;

        step(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        step(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        chk("rst_fbdsel", fbdsel, 6'b110010);
        chk("rst_idsel", idsel, 6'b111101);
        chk1("rst_clk_en", clk_en, 1'b1);
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                step(tbl[r].v, tbl[r].i, tbl[r].f, tbl[r].lk, 1'b1);
                chk1("tbl_ready", req_ready, tbl[r].e_ready);
                chk1("tbl_busy", busy, tbl[r].e_busy);
                chk1("tbl_clk_en", clk_en, tbl[r].e_clk);
                chk1("tbl_done", done, tbl[r].e_done);
                chk("tbl_fbdsel", fbdsel, tbl[r].e_fb);
                chk("tbl_idsel", idsel, tbl[r].e_id);
            end
        end

        // Lock drops in APPLY and returns 20 cycles later.
        t0 = cyc;
        step(1'b1, 6'd5, 6'd9, 1'b1, 1'b1);
        first_done = NONE;
        for (int k = 0; k < 60; k++) begin
            lk = !(cyc >= t0 + int'(G) + 1 && cyc < t0 + int'(G) + 21);
            step(1'b0, 6'd0, 6'd0, lk, 1'b1);
            if (done === 1'b1 && first_done == NONE) first_done = cyc;
        end
        chki("lockret_done_cycle", first_done - t0, int'(G) + 1 + 20 + 2 + 1);

        // Reset asserted during GATE.
        step(1'b1, 6'd7, 6'd7, 1'b1, 1'b1);
        step(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        chk("grst_fbdsel", fbdsel, 6'b110010);
        chk("grst_idsel", idsel, 6'b111101);
        chk1("grst_clk_en", clk_en, 1'b1);
        chk1("grst_ready", req_ready, 1'b1);
        chk1("grst_busy", busy, 1'b0);
        chk1("grst_done", done, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);

        // A second request while busy must not disturb the first.
        step(1'b1, 6'd1, 6'd2, 1'b1, 1'b1);
        step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
        step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
        step(1'b1, 6'd30, 6'd30, 1'b1, 1'b1);
        saw_done = 1'b0;
        for (int k = 0; k < 40 && !saw_done; k++) begin
            step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk1("ign_done_seen", saw_done, 1'b1);
        step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
        chk("ign_fbdsel", fbdsel, 6'b111101);
        chk("ign_idsel", idsel, 6'b111110);

        // Lock held low in WAIT_LOCK.
        t0 = cyc;
        step(1'b1, 6'd3, 6'd3, 1'b0, 1'b1);
        saw_done = 1'b0;
`ifdef PLLCFG_TIMEOUT_EN
        for (int k = 0; k < int'(G + S + LT) + 6; k++) begin
            step(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
            if (done === 1'b1) saw_done = 1'b1;
            if (cyc == t0 + 2 + int'(G + S + LT)) begin
                chk1("to_err", err, 1'b1);
                chk1("to_clk_en", clk_en, 1'b1);
                chk1("to_done", done, 1'b0);
            end
        end
        chk1("to_no_done", saw_done, 1'b0);
        chk("to_fbdsel_kept", fbdsel, 6'b111100);
        step(1'b1, 6'd4, 6'd4, 1'b1, 1'b1);
        chk1("to_err_cleared", err, 1'b0);
`else
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk1("nolock_no_done", saw_done, 1'b0);
        chk1("nolock_busy", busy, 1'b1);
        chk1("nolock_clk_en", clk_en, 1'b0);
        chk1("nolock_err", err, 1'b0);
`endif
        for (int k = 0; k < 30; k++) step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);

        // Randomized traffic checked by the reference model.
        for (int k = 0; k < 800; k++) begin
            logic v, rn;
            logic [5:0] ri, rf;
            v  = ($urandom_range(3) == 0);
            rn = ($urandom_range(255) != 0);
            lk = ($urandom_range(7) != 0);
            if ($urandom_range(2) == 0) begin
                ri = new_i;
                rf = new_f;
            end else begin
                ri = 6'($urandom);
                rf = 6'($urandom);
            end
            step(v, ri, rf, lk, rn);
        end
        for (int k = 0; k < 40; k++) step(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
